// File: rtl/reg_bank_pkg.sv
// Shared types and sizing constants for the feature-map register bank reader.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that absorbs stream backpressure behind the bank read pipeline.
module skid_fifo2
  import reg_bank_pkg::*;
#(
  parameter int unsigned Data_Width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [Data_Width-1:0] push_data,
  input  logic                  pop,
  output logic [Data_Width-1:0] head,
  output logic                  full,
  output logic                  empty
);

  logic [Data_Width-1:0] mem_q [BUF_DEPTH];
  logic [Data_Width-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (occ_q == OCC_W'(BUF_DEPTH));
  assign empty = (occ_q == '0);

endmodule

// File: rtl/reg_bank_reader.sv
// Sequential bank reader: issues Count reads from Base_addr and streams the words out.
module reg_bank_reader
  import reg_bank_pkg::*;
#(
  parameter int unsigned Data_Width = 32,
  parameter int unsigned Addr_Width = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [Addr_Width-1:0] Base_addr,
  input  logic [Addr_Width:0]   Count,
  output logic                  mem_rd_en,
  output logic [Addr_Width-1:0] mem_addr,
  input  logic [Data_Width-1:0] mem_rd_data,
  output logic [Data_Width-1:0] Data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CW = Addr_Width + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  state_e                state_q, state_d;
  logic [Addr_Width-1:0] base_q, base_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         xfer_cnt_q, xfer_cnt_d;
  logic                  inflight_q, inflight_d;

  logic fifo_full, fifo_empty;
  logic xfer, credit_ok, rd_en;

  always_comb begin
    xfer = ~fifo_empty & out_ready;
    // Space check is (buffered - pop + in_flight) < BUF_DEPTH, folded onto the FIFO flags.
    if (fifo_full) credit_ok = xfer & ~inflight_q;
    else           credit_ok = fifo_empty | ~inflight_q | xfer;
    rd_en = (state_q == READ) & ~flush & (issued_q < count_q) & credit_ok;
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q;
    xfer_cnt_d = xfer_cnt_q;
    inflight_d = rd_en;
    if (rd_en) issued_d = issued_q + ONE;
    if (xfer)  xfer_cnt_d = xfer_cnt_q + ONE;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = Base_addr;
          count_d    = Count;
          issued_d   = '0;
          xfer_cnt_d = '0;
          state_d    = (Count == '0) ? DONE : READ;
        end
      end
      READ:    if (rd_en && (issued_q + ONE == count_q)) state_d = DRAIN;
      DRAIN:   if (xfer && (xfer_cnt_q + ONE == count_q)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d    = IDLE;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      xfer_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      xfer_cnt_q <= xfer_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // A flush in the same cycle as a returning read clears the FIFO, dropping that word.
  skid_fifo2 #(
    .Data_Width(Data_Width)
  ) u_buf (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (flush),
    .push      (inflight_q),
    .push_data (mem_rd_data),
    .pop       (xfer),
    .head      (Data_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign mem_rd_en = rd_en;
  assign mem_addr  = base_q + issued_q[Addr_Width-1:0];
  assign out_valid = ~fifo_empty;
  assign busy      = (state_q == READ) | (state_q == DRAIN);
  assign done      = (state_q == DONE);

endmodule
